// File: rtl/bp_fe_bimodal_predictor.sv
// Bimodal branch predictor: a table of saturating counters indexed by a
// branch index. A read registers the counter MSB as the taken prediction.
// A training write moves one counter toward or away from its current
// direction depending on whether the last prediction was correct.
//
// Optional feature: define BP_FE_BIMODAL_BYPASS_EN to forward a same-cycle
// training update to a read of the same index. Without it, a read sees the
// counter value from before that cycle's write.
module bp_fe_bimodal_predictor #(
    parameter int bht_idx_width_p   = 9,
    parameter int bp_cnt_sat_bits_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic                       correct_i,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       predict_o
);

    localparam int els = 1 << bht_idx_width_p;
    localparam int n   = bp_cnt_sat_bits_p;

    // Weakly not-taken: MID-1, i.e. MSB clear and every lower bit set.
    localparam logic [n-1:0] cnt_init = {1'b0, {(n-1){1'b1}}};
    localparam logic [n-1:0] cnt_max  = {n{1'b1}};
    localparam logic [n-1:0] cnt_zero = {n{1'b0}};
    localparam logic [n-1:0] cnt_one  = {{(n-1){1'b0}}, 1'b1};

    logic [n-1:0] bht_r [els];
    logic [n-1:0] cnt_w;
    logic [n-1:0] cnt_w_next;
    logic         taken_w;
    logic         read_bit;

    // Next value of the counter being trained. A mispredict can never wrap:
    // MSB set implies the counter is above zero, MSB clear implies below MAX.
    always_comb begin
        cnt_w      = bht_r[idx_w_i];
        taken_w    = cnt_w[n-1];
        cnt_w_next = cnt_w;
        if (correct_i) begin
            if (taken_w) begin
                cnt_w_next = (cnt_w == cnt_max) ? cnt_max : cnt_w + cnt_one;
            end else begin
                cnt_w_next = (cnt_w == cnt_zero) ? cnt_zero : cnt_w - cnt_one;
            end
        end else begin
            if (taken_w) begin
                cnt_w_next = cnt_w - cnt_one;
            end else begin
                cnt_w_next = cnt_w + cnt_one;
            end
        end
    end

    // Prediction bit presented to the output register.
    always_comb begin
        read_bit = bht_r[idx_r_i][n-1];
`ifdef BP_FE_BIMODAL_BYPASS_EN
        if (w_v_i && (idx_w_i == idx_r_i)) begin
            read_bit = cnt_w_next[n-1];
        end
`endif
    end

    // Counter table: reset to weakly not-taken, one entry trained per cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els; i++) begin
                bht_r[i] <= cnt_init;
            end
        end else if (w_v_i) begin
            bht_r[idx_w_i] <= cnt_w_next;
        end
    end

    // Registered prediction; holds its value when no read is requested.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            predict_o <= 1'b0;
        end else if (r_v_i) begin
            predict_o <= read_bit;
        end
    end

endmodule

// File: tb/tb_bp_fe_bimodal_predictor.sv
// Directed bench for bp_fe_bimodal_predictor: a default 2-bit instance
// (512 entries) and a 3-bit instance (8 entries), each on its own inputs.
module tb_bp_fe_bimodal_predictor;

    logic       clk_i = 1'b0;
    logic       reset_n_i;

    logic       w_v_a, correct_a, r_v_a, predict_a;
    logic [8:0] idx_w_a, idx_r_a;

    logic       w_v_b, correct_b, r_v_b, predict_b;
    logic [2:0] idx_w_b, idx_r_b;

    int checks = 0;
    int errors = 0;

    bp_fe_bimodal_predictor #(
        .bht_idx_width_p(9),
        .bp_cnt_sat_bits_p(2)
    ) dut_a (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .w_v_i(w_v_a), .idx_w_i(idx_w_a), .correct_i(correct_a),
        .r_v_i(r_v_a), .idx_r_i(idx_r_a), .predict_o(predict_a)
    );

    bp_fe_bimodal_predictor #(
        .bht_idx_width_p(3),
        .bp_cnt_sat_bits_p(3)
    ) dut_b (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .w_v_i(w_v_b), .idx_w_i(idx_w_b), .correct_i(correct_b),
        .r_v_i(r_v_b), .idx_r_i(idx_r_b), .predict_o(predict_b)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_a(input int idx, input logic c);
        w_v_a = 1'b1; idx_w_a = 9'(idx); correct_a = c;
        tick();
        w_v_a = 1'b0;
    endtask

    task automatic rd_a(input string tag, input int idx, input logic exp);
        r_v_a = 1'b1; idx_r_a = 9'(idx);
        tick();
        r_v_a = 1'b0;
        check(tag, predict_a, exp);
    endtask

    task automatic wr_b(input int idx, input logic c);
        w_v_b = 1'b1; idx_w_b = 3'(idx); correct_b = c;
        tick();
        w_v_b = 1'b0;
    endtask

    task automatic rd_b(input string tag, input int idx, input logic exp);
        r_v_b = 1'b1; idx_r_b = 3'(idx);
        tick();
        r_v_b = 1'b0;
        check(tag, predict_b, exp);
    endtask

    initial begin
        logic bypass_exp;
`ifdef BP_FE_BIMODAL_BYPASS_EN
        bypass_exp = 1'b1;
`else
        bypass_exp = 1'b0;
`endif
        reset_n_i = 1'b0;
        w_v_a = 0; correct_a = 0; r_v_a = 0; idx_w_a = '0; idx_r_a = '0;
        w_v_b = 0; correct_b = 0; r_v_b = 0; idx_w_b = '0; idx_r_b = '0;
        tick();
        tick();
        check("reset_predict_a", predict_a, 1'b0);
        check("reset_predict_b", predict_b, 1'b0);
        reset_n_i = 1'b1;
        tick();

        // Reset state reads weakly not-taken everywhere.
        rd_a("rd_idx0", 0, 1'b0);
        rd_a("rd_idx5", 5, 1'b0);
        rd_a("rd_idx511", 511, 1'b0);

        // Mispredicts cross the MID boundary both ways.
        wr_a(3, 1'b0);                       // 01 -> 10
        rd_a("idx3_mis1", 3, 1'b1);
        wr_a(3, 1'b0);                       // 10 -> 01
        rd_a("idx3_mis2", 3, 1'b0);
        wr_a(3, 1'b0);                       // 01 -> 10
        wr_a(3, 1'b1);                       // 10 -> 11
        wr_a(3, 1'b1);                       // 11 stays
        rd_a("idx3_sat11", 3, 1'b1);

        // Leaving saturation at 11.
        wr_a(3, 1'b0);                       // 11 -> 10
        rd_a("idx3_11_mis", 3, 1'b1);
        wr_a(3, 1'b0);                       // 10 -> 01
        rd_a("idx3_10_mis", 3, 1'b0);

        // Saturation at 00.
        wr_a(9, 1'b1);                       // 01 -> 00
        wr_a(9, 1'b1);                       // 00 stays
        wr_a(9, 1'b0);                       // 00 -> 01
        rd_a("idx9_00_mis", 9, 1'b0);
        wr_a(9, 1'b0);                       // 01 -> 10
        rd_a("idx9_01_mis", 9, 1'b1);

        // predict_o holds while r_v_i is low.
        wr_a(3, 1'b0);                       // 01 -> 10
        wr_a(3, 1'b1);                       // 10 -> 11
        rd_a("idx3_hold_rd", 3, 1'b1);
        wr_a(20, 1'b1);                      // 01 -> 00
        check("hold_1", predict_a, 1'b1);
        wr_a(20, 1'b1);                      // 00 stays
        check("hold_2", predict_a, 1'b1);
        rd_a("idx20_rd", 20, 1'b0);

        // Same-cycle write and read of one index.
        w_v_a = 1'b1; idx_w_a = 9'd40; correct_a = 1'b0;   // 01 -> 10
        r_v_a = 1'b1; idx_r_a = 9'd40;
        tick();
        w_v_a = 1'b0; r_v_a = 1'b0;
        check("same_idx_rw", predict_a, bypass_exp);
        rd_a("idx40_after", 40, 1'b1);

        // Same-cycle write and read of different indices.
        w_v_a = 1'b1; idx_w_a = 9'd42; correct_a = 1'b0;   // 01 -> 10
        r_v_a = 1'b1; idx_r_a = 9'd41;
        tick();
        w_v_a = 1'b0; r_v_a = 1'b0;
        check("diff_idx_rw", predict_a, 1'b0);
        rd_a("idx42_after", 42, 1'b1);

        // Reset mid-operation: output clears at once, training discarded,
        // and writes during reset are ignored.
        reset_n_i = 1'b0;
        #1;
        check("midreset_predict", predict_a, 1'b0);
        w_v_a = 1'b1; idx_w_a = 9'd50; correct_a = 1'b0;
        r_v_a = 1'b1; idx_r_a = 9'd3;
        tick();
        check("midreset_read_ignored", predict_a, 1'b0);
        w_v_a = 1'b0; r_v_a = 1'b0;
        reset_n_i = 1'b1;
        tick();
        rd_a("idx50_ignored", 50, 1'b0);
        rd_a("idx3_cleared", 3, 1'b0);
        rd_a("idx42_cleared", 42, 1'b0);

        // 3-bit counters: idx 6 set to 4 first so a stray write is visible.
        wr_b(6, 1'b0);                       // 3 -> 4
        wr_b(7, 1'b0);                       // 3 -> 4
        rd_b("n3_mis_3to4", 7, 1'b1);
        for (int i = 0; i < 4; i++) wr_b(7, 1'b1);   // 5,6,7,7
        rd_b("n3_sat7", 7, 1'b1);
        for (int i = 0; i < 3; i++) wr_b(7, 1'b0);   // 6,5,4
        rd_b("n3_at4", 7, 1'b1);
        wr_b(7, 1'b0);                       // 4 -> 3
        rd_b("n3_back3", 7, 1'b0);
        rd_b("n3_idx6", 6, 1'b1);
        wr_b(6, 1'b0);                       // 4 -> 3
        rd_b("n3_idx6_mis", 6, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
